// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between the fetch and data
// requesters, one transaction outstanding at a time.
// Build option: define ARB_RR_EN to alternate grants when both requesters
// collide; otherwise data always wins over fetch.
module mem_port_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_ready,
    output logic                if_stall,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_mask,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ready,
    output logic                d_stall,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_mask,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                arb_busy
);

    localparam int MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t              state_reg, state_next;
    logic                owner_reg;       // 0 = fetch, 1 = data
    logic                last_owner_reg;
    logic                we_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic [MASK_W-1:0]   mask_reg;
    logic [DATA_W-1:0]   if_rdata_reg;
    logic [DATA_W-1:0]   d_rdata_reg;
    logic                sel_data;
    logic                any_req;

    assign any_req = if_req | d_req;

    // Owner selection for the IDLE cycle; a lone request always wins.
`ifdef ARB_RR_EN
    always_comb begin
        sel_data = d_req & (~if_req | ~last_owner_reg);
    end
`else
    logic unused_last_owner;
    assign unused_last_owner = last_owner_reg;

    always_comb begin
        sel_data = d_req;
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Next-state logic; gnt/rvalid only matter in their own states.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (any_req)    state_next = ISSUE;
            ISSUE:   if (mem_gnt)    state_next = WAIT;
            WAIT:    if (mem_rvalid) state_next = DONE;
            DONE:                    state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // Payload capture in IDLE and response capture in WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_reg      <= 1'b0;
            last_owner_reg <= 1'b0;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            mask_reg       <= '0;
            if_rdata_reg   <= '0;
            d_rdata_reg    <= '0;
        end else begin
            if (state_reg == IDLE && any_req) begin
                owner_reg <= sel_data;
                if (sel_data) begin
                    we_reg    <= d_we;
                    addr_reg  <= d_addr;
                    wdata_reg <= d_wdata;
                    mask_reg  <= d_mask;
                end else begin
                    // A fetch reads the whole word and carries no store data.
                    we_reg    <= 1'b0;
                    addr_reg  <= if_addr;
                    wdata_reg <= '0;
                    mask_reg  <= '1;
                end
            end
            if (state_reg == WAIT && mem_rvalid) begin
                last_owner_reg <= owner_reg;
                if (!owner_reg)   if_rdata_reg <= mem_rdata;
                else if (!we_reg) d_rdata_reg  <= mem_rdata;
            end
        end
    end

    assign mem_req   = (state_reg == ISSUE);
    assign mem_we    = (state_reg == ISSUE) & we_reg;
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign mem_mask  = mask_reg;
    assign if_rdata  = if_rdata_reg;
    assign d_rdata   = d_rdata_reg;
    assign if_ready  = (state_reg == DONE) & ~owner_reg;
    assign d_ready   = (state_reg == DONE) &  owner_reg;
    assign if_stall  = if_req & ~if_ready;
    assign d_stall   = d_req & ~d_ready;
    assign arb_busy  = (state_reg != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench with a scoreboard of expected
// completions (owner and returned data), checked at each DONE cycle.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_ready, if_stall;
    logic [63:0] if_addr, if_rdata;
    logic        d_req, d_we, d_ready, d_stall;
    logic [63:0] d_addr, d_wdata, d_rdata;
    logic [7:0]  d_mask, mem_mask;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid, arb_busy;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;

    typedef struct {
        bit          is_data;
        logic [63:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   t0;
    bit   first_data;

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_ready(if_ready), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_mask(d_mask), .d_rdata(d_rdata), .d_ready(d_ready), .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_mask(mem_mask), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .arb_busy(arb_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit is_data, input logic [63:0] rdata);
        exp_t e;
        e.is_data = is_data;
        e.rdata   = rdata;
        sb.push_back(e);
    endtask

    // Plays the memory for one transaction, entered in the ISSUE cycle and
    // left in the DONE cycle, where the scoreboard entry is retired.
    task automatic serve(input string tag, input logic [63:0] ea, input bit ewe,
                         input logic [63:0] ewd, input logic [7:0] emk,
                         input int gw, input int rw, input logic [63:0] rd,
                         input bit stray, input int start, input int lat);
        exp_t e;
        check({tag, "_req"},   mem_req, 1'b1);
        check({tag, "_addr"},  mem_addr, ea);
        check({tag, "_we"},    mem_we, ewe);
        check({tag, "_wdata"}, mem_wdata, ewd);
        check({tag, "_mask"},  mem_mask, emk);
        for (int i = 0; i < gw; i++) begin
            tick();
            check({tag, "_req_hold"},   mem_req, 1'b1);
            check({tag, "_addr_hold"},  mem_addr, ea);
            check({tag, "_wdata_hold"}, mem_wdata, ewd);
            check({tag, "_mask_hold"},  mem_mask, emk);
        end
        mem_gnt    = 1'b1;
        mem_rvalid = stray;
        mem_rdata  = 64'hDEAD_DEAD_DEAD_DEAD;
        tick();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        check({tag, "_req_wait"}, mem_req, 1'b0);
        check({tag, "_we_wait"},  mem_we, 1'b0);
        check({tag, "_rdy_wait"}, {if_ready, d_ready}, 2'b00);
        for (int i = 0; i < rw; i++) begin
            tick();
            check({tag, "_rdy_rwait"}, {if_ready, d_ready}, 2'b00);
        end
        mem_rvalid = 1'b1;
        mem_rdata  = rd;
        tick();
        mem_rvalid = 1'b0;
        check({tag, "_latency"}, cyc - start, lat);
        check({tag, "_sb_nonempty"}, sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_if_ready"}, if_ready, !e.is_data);
            check({tag, "_d_ready"},  d_ready, e.is_data);
            if (e.is_data) check({tag, "_d_rdata"}, d_rdata, e.rdata);
            else           check({tag, "_if_rdata"}, if_rdata, e.rdata);
        end
    endtask

    initial begin
        rst = 1'b1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0;
        d_wdata = 0; d_mask = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        tick();
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 64'h0);
        check("rst_mem_mask", mem_mask, 8'h0);
        check("rst_rdata", {if_rdata, d_rdata}, 128'h0);
        check("rst_ready_busy", {if_ready, d_ready, arb_busy}, 3'b000);
        tick();
        rst = 1'b0;

        // Lone fetch, zero-wait memory.
        if_req = 1; if_addr = 64'h1000; t0 = cyc;
        push(1'b0, 64'h0000_0013_0000_0093);
        #1;
        check("t1_stall_pending", if_stall, 1'b1);
        check("t1_idle_req", mem_req, 1'b0);
        tick();
        serve("t1", 64'h1000, 1'b0, 64'h0, 8'hFF, 0, 0, 64'h0000_0013_0000_0093, 1'b0, t0, 3);
        check("t1_stall_done", if_stall, 1'b0);
        if_req = 0;
        tick();
        check("t1_idle_after", {mem_req, if_ready, arb_busy}, 3'b000);

        // Both requesters collide: data first (last owner is fetch in both builds).
        if_req = 1; if_addr = 64'h1000;
        d_req = 1; d_we = 0; d_addr = 64'h2000; d_wdata = 64'h0; d_mask = 8'hFF;
        t0 = cyc;
        push(1'b1, 64'hAAAA_0000_0000_2000);
        push(1'b0, 64'h0000_0000_0000_1337);
        tick();
        serve("t2d", 64'h2000, 1'b0, 64'h0, 8'hFF, 0, 0, 64'hAAAA_0000_0000_2000, 1'b0, t0, 3);
        d_req = 0;
        #1;
        check("t2_fetch_stalled", if_stall, 1'b1);
        tick();
        tick();
        serve("t2f", 64'h1000, 1'b0, 64'h0, 8'hFF, 0, 0, 64'h0000_0000_0000_1337, 1'b0, t0, 7);
        if_req = 0;
        tick();

        // Load with grant withheld for 4 cycles.
        d_req = 1; d_we = 0; d_addr = 64'h2010; d_wdata = 64'h55AA; d_mask = 8'hFF;
        t0 = cyc;
        push(1'b1, 64'h1111_2222_3333_4444);
        tick();
        serve("t3", 64'h2010, 1'b0, 64'h55AA, 8'hFF, 4, 0, 64'h1111_2222_3333_4444, 1'b0, t0, 7);
        d_req = 0;
        tick();

        // Store: d_rdata must keep the previous load value.
        d_req = 1; d_we = 1; d_addr = 64'h3008; d_wdata = 64'hDEADBEEF; d_mask = 8'h0F;
        t0 = cyc;
        push(1'b1, 64'h1111_2222_3333_4444);
        tick();
        serve("t4", 64'h3008, 1'b1, 64'hDEADBEEF, 8'h0F, 0, 0, 64'h0BAD, 1'b0, t0, 3);
        d_req = 0; d_we = 0;
        tick();
        check("t4_we_idle", mem_we, 1'b0);

        // Collision after a data transaction: alternating policy picks fetch.
`ifdef ARB_RR_EN
        first_data = 1'b0;
`else
        first_data = 1'b1;
`endif
        if_req = 1; if_addr = 64'h1040;
        d_req = 1; d_we = 0; d_addr = 64'h2020; d_wdata = 64'h0; d_mask = 8'hFF;
        t0 = cyc;
        if (first_data) begin
            push(1'b1, 64'hD5D5_0000_0000_2020);
            push(1'b0, 64'hF5F5_0000_0000_1040);
        end else begin
            push(1'b0, 64'hF5F5_0000_0000_1040);
            push(1'b1, 64'hD5D5_0000_0000_2020);
        end
        tick();
        if (first_data) begin
            serve("t5d", 64'h2020, 1'b0, 64'h0, 8'hFF, 0, 0, 64'hD5D5_0000_0000_2020, 1'b0, t0, 3);
            d_req = 0;
            tick(); tick();
            serve("t5f", 64'h1040, 1'b0, 64'h0, 8'hFF, 0, 0, 64'hF5F5_0000_0000_1040, 1'b0, t0, 7);
            if_req = 0;
        end else begin
            serve("t5f", 64'h1040, 1'b0, 64'h0, 8'hFF, 0, 0, 64'hF5F5_0000_0000_1040, 1'b0, t0, 3);
            if_req = 0;
            tick(); tick();
            serve("t5d", 64'h2020, 1'b0, 64'h0, 8'hFF, 0, 0, 64'hD5D5_0000_0000_2020, 1'b0, t0, 7);
            d_req = 0;
        end
        tick();

        // Reset in WAIT, followed by a late rvalid.
        if_req = 1; if_addr = 64'h4000;
        tick();
        mem_gnt = 1;
        tick();
        mem_gnt = 0; rst = 1;
        tick();
        rst = 0; if_req = 0; mem_rvalid = 1; mem_rdata = 64'h77;
        check("t6_rst_mem", {mem_req, mem_we, mem_mask}, 10'h0);
        check("t6_rst_addr", mem_addr, 64'h0);
        check("t6_rst_wdata", mem_wdata, 64'h0);
        check("t6_rst_d_rdata", d_rdata, 64'h0);
        check("t6_rst_if_rdata", if_rdata, 64'h0);
        check("t6_rst_flags", {if_ready, d_ready, arb_busy}, 3'b000);
        tick();
        mem_rvalid = 0;
        check("t6_late_rvalid", {if_ready, d_ready, arb_busy}, 3'b000);
        check("t6_late_rdata", if_rdata, 64'h0);
        if_req = 1; if_addr = 64'h5000; t0 = cyc;
        push(1'b0, 64'h5555);
        tick();
        serve("t6", 64'h5000, 1'b0, 64'h0, 8'hFF, 0, 0, 64'h5555, 1'b0, t0, 3);
        if_req = 0;
        tick();

        // Stray rvalid in IDLE and rvalid coincident with gnt.
        mem_rvalid = 1; mem_rdata = 64'hFFFF;
        tick();
        mem_rvalid = 0;
        check("t7_idle_rvalid_rdata", if_rdata, 64'h5555);
        check("t7_idle_rvalid_flags", {if_ready, d_ready, arb_busy}, 3'b000);
        if_req = 1; if_addr = 64'h6000; t0 = cyc;
        push(1'b0, 64'h6666);
        tick();
        serve("t7", 64'h6000, 1'b0, 64'h0, 8'hFF, 0, 1, 64'h6666, 1'b1, t0, 4);
        if_req = 0;
        tick();

        check("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
